ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes rs1_data, rs2_data and rd_address from ID/EX. It runs a radix-2 shift-add multiply or restoring divide and drives stall, which holds ID/EX wren low until the result is ready. The result and destination register go to the EX/MEM pipeline register, qualified by done.

---
 rtl/ex_muldiv_unit_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Handshake bundle between ID/EX, the EX-stage mul/div unit and EX/MEM.
// The master side drives the op; the slave side is the mul/div unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      in_rd_address;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_address;

    modport master (
        output start, funct, rs1_data, rs2_data,
        output in_rd_address, flush,
        input  stall, done, result, rd_address
    );

    modport slave (
        input  start, funct, rs1_data, rs2_data,
        input  in_rd_address, flush,
        output stall, done, result, rd_address
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) for the EX stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    ex_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              negr_q, negr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              done_q, done_d;
    logic              stall_c;

    logic              is_div, s1, s2, sg1, sg2;
    logic [XLEN-1:0]   mag1, mag2, spec_res;
    logic              div0, ovf;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc, prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_sh, div_diff, div_rem;
    logic              div_qb;
    logic [XLEN-1:0]   div_quo, quo, rem, div_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;
    logic [XLEN-1:0]          fast_res;
`endif

    // Operand decode at accept
    always_comb begin
        is_div = bus.funct[2];
        s1 = (bus.funct == 3'b001) || (bus.funct == 3'b010) ||
             (bus.funct == 3'b100) || (bus.funct == 3'b110);
        s2 = (bus.funct == 3'b001) || (bus.funct == 3'b100) ||
             (bus.funct == 3'b110);
        sg1 = s1 && bus.rs1_data[XLEN-1];
        sg2 = s2 && bus.rs2_data[XLEN-1];
        mag1 = sg1 ? -bus.rs1_data : bus.rs1_data;
        mag2 = sg2 ? -bus.rs2_data : bus.rs2_data;
        div0 = is_div && (bus.rs2_data == '0);
        ovf = is_div && !bus.funct[0] &&
              (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
              (bus.rs2_data == '1);
        if (div0)
            spec_res = bus.funct[1] ? bus.rs1_data : '1;
        else
            spec_res = bus.funct[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fa = {sg1, bus.rs1_data};
        fb = {sg2, bus.rs2_data};
        fp = (2*XLEN+2)'(fa) * (2*XLEN+2)'(fb);
        if (bus.funct[1:0] == 2'b00)
            fast_res = fp[XLEN-1:0];
        else
            fast_res = fp[2*XLEN-1:XLEN];
    end
`endif

    // One datapath step plus the signed fix-up of its outcome
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_acc = {mul_sum, acc_q[XLEN-1:1]};
        prod = neg_q ? -mul_acc : mul_acc;
        if (funct_q[1:0] == 2'b00)
            mul_res = prod[XLEN-1:0];
        else
            mul_res = prod[2*XLEN-1:XLEN];

        div_sh = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_qb = ~div_diff[XLEN];
        div_rem = div_qb ? div_diff : div_sh;
        div_quo = {opa_q[XLEN-2:0], div_qb};
        quo = neg_q ? -div_quo : div_quo;
        rem = negr_q ? -div_rem[XLEN-1:0] : div_rem[XLEN-1:0];
        div_res = funct_q[1] ? rem : quo;
    end

    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall_c = 1'b1;
                    funct_d = bus.funct;
                    rd_d    = bus.in_rd_address;
                    opa_d   = mag1;
                    opb_d   = mag2;
                    neg_d   = sg1 ^ sg2;
                    negr_d  = sg1;
                    cnt_d   = '1;
                    acc_d   = is_div ? '0 : {{XLEN{1'b0}}, mag2};
                    if (div0 || ovf) begin
                        res_d   = spec_res;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        res_d   = fast_res;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (funct_q[2]) begin
                        acc_d = {{(XLEN-1){1'b0}}, div_rem};
                        opa_d = div_quo;
                    end else begin
                        acc_d = mul_acc;
                    end
                    if (cnt_q == '0) begin
                        res_d   = funct_q[2] ? div_res : mul_res;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            funct_q <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign bus.stall      = !reset && stall_c;
    assign bus.done       = done_q;
    assign bus.result     = res_q;
    assign bus.rd_address = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, special cases,
// flush and mid-operation reset.
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The op stays presented while stalled and leaves after FINISH.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int lat);
        logic ok;
        ok = 1'b1;
        bus.start = 1'b1;
        bus.funct = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.in_rd_address = rd;
        #1;
        chk({tag, ":stall_t0"}, {31'b0, bus.stall}, 32'd1);
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c < lat && (bus.stall !== 1'b1 || bus.done !== 1'b0))
                ok = 1'b0;
        end
        chk({tag, ":busy"}, {31'b0, ok}, 32'd1);
        chk({tag, ":done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, ":stall_fin"}, {31'b0, bus.stall}, 32'd0);
        chk({tag, ":result"}, bus.result, exp);
        chk({tag, ":rd"}, {27'b0, bus.rd_address}, {27'b0, rd});
        tick();
        bus.start = 1'b0;
        #1;
        chk({tag, ":pulse"}, {31'b0, bus.done}, 32'd0);
        chk({tag, ":idle"}, {31'b0, bus.stall}, 32'd0);
        chk({tag, ":hold"}, bus.result, exp);
    endtask

    initial begin
        logic ok;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.funct = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.in_rd_address = '0;
        bus.flush = 1'b0;
        tick();
        tick();
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_rd", {27'b0, bus.rd_address}, 32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        tick();

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
               32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
               32'h0000_0000, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8,
               32'hFFFF_FFFF, MUL_LAT);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10,
               32'hFFFF_FFFD, 33);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11,
               32'hFFFF_FFFF, 33);
        run_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 33);
        run_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 33);
        run_op("divu0", 3'b101, 32'd5, 32'd0, 5'd14,
               32'hFFFF_FFFF, 1);
        run_op("rem0", 3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
               32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
               32'h0000_0000, 1);

        // start with flush in IDLE is not accepted
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.funct = 3'b101;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        #1;
        chk("iflush_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("iflush_next", {31'b0, bus.stall}, 32'd0);
        chk("iflush_done", {31'b0, bus.done}, 32'd0);

        // flush mid-CALC
        bus.start = 1'b1;
        bus.funct = 3'b100;
        bus.in_rd_address = 5'd20;
        tick();
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("cflush_t10", {31'b0, bus.stall}, 32'd1);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("cflush_t11", {31'b0, bus.stall}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (bus.done !== 1'b0 || bus.stall !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("cflush_quiet", {31'b0, ok}, 32'd1);
        run_op("mul34", 3'b000, 32'd3, 32'd4, 5'd9, 32'd12, MUL_LAT);

        // reset mid-CALC
        bus.start = 1'b1;
        bus.funct = 3'b101;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        bus.in_rd_address = 5'd3;
        tick();
        for (int i = 0; i < 9; i++) tick();
        bus.start = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_done", {31'b0, bus.done}, 32'd0);
        chk("mrst_result", bus.result, 32'd0);
        chk("mrst_rd", {27'b0, bus.rd_address}, 32'd0);
        chk("mrst_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.stall !== 1'b0) ok = 1'b0;
        end
        chk("mrst_quiet", {31'b0, ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
